// File: rtl/mem_wb_stage_pkg.sv
// Shared constants for the memory/write-back stage: funct3 size codes,
// FSM state encodings, the latched access descriptor and the legality rule.
package mem_wb_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // Fields of an in-flight access needed again when the cache answers.
    typedef struct packed {
        logic       regwrite;
        logic [2:0] funct3;
        logic [1:0] off;
    } mem_ctl_t;

    // funct3[1:0] encodes the access size, so it also sets the alignment rule.
    function automatic logic mem_op_legal(input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic f3_ok;
        if (is_store)
            f3_ok = funct3 inside {F3_B, F3_H, F3_W};
        else
            f3_ok = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        case (funct3[1:0])
            2'b00:   return f3_ok;
            2'b01:   return f3_ok & ~addr_lo[0];
            default: return f3_ok & (addr_lo == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX/MEM bundle, data-cache port and register-file write port of the stage.
// master is the stage's own view; slave is the surrounding pipeline/cache.
interface mem_wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_regwrite;
    logic              ex_memread;
    logic              ex_memwrite;
    logic [2:0]        ex_funct3;
    logic [DATA_W-1:0] ex_alu_result;
    logic [DATA_W-1:0] ex_store_data;

    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall;
    logic              wb_wen;
    logic [REG_AW-1:0] wb_wa;
    logic [DATA_W-1:0] wb_wd;
    logic              mem_fault;

    modport master (
        input  ex_valid, ex_rd, ex_regwrite, ex_memread, ex_memwrite,
               ex_funct3, ex_alu_result, ex_store_data, mem_ready, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
               stall, wb_wen, wb_wa, wb_wd, mem_fault
    );

    modport slave (
        output ex_valid, ex_rd, ex_regwrite, ex_memread, ex_memwrite,
               ex_funct3, ex_alu_result, ex_store_data, mem_ready, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
               stall, wb_wen, wb_wa, wb_wd, mem_fault
    );

endinterface

// File: rtl/mem_wb_stage_load_extend.sv
// Load aligner: picks the addressed byte/halfword out of a raw word and extends it.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module load_extend
    import mem_wb_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[8*off +: 8];
        lane_h = rdata[16*off[1] +: 16];
        result = rdata;
        case (funct3)
            F3_B:    result = {{24{lane_b[7]}}, lane_b};
            F3_BU:   result = {24'd0, lane_b};
            F3_H:    result = {{16{lane_h[15]}}, lane_h};
            F3_HU:   result = {16'd0, lane_h};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// RV32I MEM/WB stage: data-cache load/store, load alignment, register-file write-back.
// Latency: ALU result written back 1 cycle after acceptance; loads 1 cycle after mem_ready.
// Backpressure: stall (combinational) holds upstream from acceptance until mem_ready.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic           clock,
    input  logic           reset,
    mem_wb_stage_if.master bus
);

    state_t            state, state_nx;
    mem_ctl_t          ctl_q;
    logic [REG_AW-1:0] rd_q;

    logic              mem_req_q, mem_we_q, wb_wen_q, fault_q;
    logic [DATA_W-1:0] addr_q, wdata_q, wb_wd_q;
    logic [3:0]        be_q;
    logic [REG_AW-1:0] wb_wa_q;

    logic              is_mem, legal, stall_c;
    logic [1:0]        off;
    logic [3:0]        be_nx;
    logic [DATA_W-1:0] wdata_nx;
    logic [31:0]       load_val;

    assign is_mem = bus.ex_memread | bus.ex_memwrite;
    assign legal  = mem_op_legal(bus.ex_memwrite, bus.ex_funct3, bus.ex_alu_result[1:0]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_RUN;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        stall_c  = 1'b0;
        case (state)
            S_RUN: begin
                if (bus.ex_valid && is_mem && legal) begin
                    state_nx = S_WAIT;
                    stall_c  = 1'b1;
                end
            end
            S_WAIT: begin
                stall_c = ~bus.mem_ready;
                if (bus.mem_ready) state_nx = S_RUN;
            end
        endcase
    end

    // Store lanes: the cache picks the bytes out of a replicated word via mem_be.
    always_comb begin
        off = bus.ex_alu_result[1:0];
        case (bus.ex_funct3[1:0])
            2'b00: begin
                be_nx    = 4'b0001 << off;
                wdata_nx = {4{bus.ex_store_data[7:0]}};
            end
            2'b01: begin
                be_nx    = 4'b0011 << off;
                wdata_nx = {2{bus.ex_store_data[15:0]}};
            end
            default: begin
                be_nx    = 4'hF;
                wdata_nx = bus.ex_store_data;
            end
        endcase
    end

    load_extend u_load_extend (
        .rdata  (bus.mem_rdata),
        .off    (ctl_q.off),
        .funct3 (ctl_q.funct3),
        .result (load_val)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            wb_wen_q  <= 1'b0;
            wb_wa_q   <= '0;
            wb_wd_q   <= '0;
            fault_q   <= 1'b0;
            ctl_q     <= '0;
            rd_q      <= '0;
        end else begin
            wb_wen_q <= 1'b0;
            fault_q  <= 1'b0;
            case (state)
                S_RUN: begin
                    if (bus.ex_valid) begin
                        if (!is_mem) begin
                            // wb_wa/wb_wd only move on a real write so they hold otherwise.
                            if (bus.ex_regwrite && bus.ex_rd != '0) begin
                                wb_wen_q <= 1'b1;
                                wb_wa_q  <= bus.ex_rd;
                                wb_wd_q  <= bus.ex_alu_result;
                            end
                        end else if (!legal) begin
                            fault_q <= 1'b1;
                        end else begin
                            mem_req_q      <= 1'b1;
                            mem_we_q       <= bus.ex_memwrite;
                            addr_q         <= {bus.ex_alu_result[DATA_W-1:2], 2'b00};
                            be_q           <= be_nx;
                            wdata_q        <= wdata_nx;
                            ctl_q.regwrite <= bus.ex_regwrite;
                            ctl_q.funct3   <= bus.ex_funct3;
                            ctl_q.off      <= off;
                            rd_q           <= bus.ex_rd;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.mem_ready) begin
                        mem_req_q <= 1'b0;
                        if (!mem_we_q && ctl_q.regwrite && rd_q != '0) begin
                            wb_wen_q <= 1'b1;
                            wb_wa_q  <= rd_q;
                            wb_wd_q  <= load_val;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;
    assign bus.stall     = stall_c;
    assign bus.wb_wen    = wb_wen_q;
    assign bus.wb_wa     = wb_wa_q;
    assign bus.wb_wd     = wb_wd_q;
    assign bus.mem_fault = fault_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed and randomized checks of mem_wb_stage against an arithmetic reference model.
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mem_wb_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

    mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // ---- reference model, straight from the ISA rules ----
    function automatic logic ref_legal(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        if (st) begin
            if (f3 > 3'd2) return 1'b0;
        end else if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin
            return 1'b0;
        end
        sz = 1 << f3[1:0];
        return (a % sz) == 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128)   ? b - 256   : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        int nbytes;
        nbytes = 1 << f3[1:0];
        return 4'(((1 << nbytes) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (f3[1:0])
            2'd0:    return (sd & 32'hFF) * 32'h0101_0101;
            2'd1:    return (sd & 32'hFFFF) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_req"},   32'(bus.mem_req),   0);
        chk({tag, "_we"},    32'(bus.mem_we),    0);
        chk({tag, "_addr"},  bus.mem_addr,       0);
        chk({tag, "_wdata"}, bus.mem_wdata,      0);
        chk({tag, "_be"},    32'(bus.mem_be),    0);
        chk({tag, "_wen"},   32'(bus.wb_wen),    0);
        chk({tag, "_wa"},    32'(bus.wb_wa),     0);
        chk({tag, "_wd"},    bus.wb_wd,          0);
        chk({tag, "_fault"}, 32'(bus.mem_fault), 0);
        chk({tag, "_stall"}, 32'(bus.stall),     0);
    endtask

    // Issue one instruction at a negedge and follow it to completion.
    task automatic do_op(input logic rw, input logic [4:0] rd, input logic mr, input logic mw,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                         input int waits, input logic [31:0] rdata);
        logic is_mem, ok, wen;
        int   stalls;
        is_mem = mr | mw;
        ok     = is_mem && ref_legal(mw, f3, a);
        bus.ex_valid      = 1'b1;
        bus.ex_rd         = rd;
        bus.ex_regwrite   = rw;
        bus.ex_memread    = mr;
        bus.ex_memwrite   = mw;
        bus.ex_funct3     = f3;
        bus.ex_alu_result = a;
        bus.ex_store_data = sd;
        bus.mem_ready     = 1'($urandom_range(0, 1));
        bus.mem_rdata     = $urandom();
        #1 chk("stall_accept", 32'(bus.stall), 32'(ok));
        stalls = ok ? 1 : 0;
        step();
        bus.ex_valid  = 1'b0;
        bus.mem_ready = 1'b0;
        if (!is_mem) begin
            wen = rw && (rd != 0);
            if (wen) begin
                exp_wa = rd;
                exp_wd = a;
            end
            chk("alu_wen",   32'(bus.wb_wen),    32'(wen));
            chk("alu_wa",    32'(bus.wb_wa),     32'(exp_wa));
            chk("alu_wd",    bus.wb_wd,          exp_wd);
            chk("alu_req",   32'(bus.mem_req),   0);
            chk("alu_fault", 32'(bus.mem_fault), 0);
        end else if (!ok) begin
            chk("fault_pulse", 32'(bus.mem_fault), 1);
            chk("fault_req",   32'(bus.mem_req),   0);
            chk("fault_wen",   32'(bus.wb_wen),    0);
            step();
            chk("fault_clear", 32'(bus.mem_fault), 0);
            chk("fault_req2",  32'(bus.mem_req),   0);
        end else begin
            chk("req_rise",  32'(bus.mem_req),   1);
            chk("req_we",    32'(bus.mem_we),    32'(mw));
            chk("req_addr",  bus.mem_addr,       a & ~32'h3);
            chk("req_wen",   32'(bus.wb_wen),    0);
            chk("req_fault", 32'(bus.mem_fault), 0);
            if (mw) begin
                chk("st_be",    32'(bus.mem_be), 32'(ref_be(f3, a)));
                chk("st_wdata", bus.mem_wdata,   ref_wdata(f3, sd));
            end
            for (int i = 0; i < waits; i++) begin
                bus.ex_valid      = 1'b1;
                bus.ex_memread    = 1'($urandom_range(0, 1));
                bus.ex_funct3     = 3'($urandom_range(0, 7));
                bus.ex_alu_result = $urandom();
                bus.mem_rdata     = $urandom();
                #1 if (bus.stall) stalls++;
                step();
                chk("wait_req",  32'(bus.mem_req), 1);
                chk("wait_addr", bus.mem_addr,     a & ~32'h3);
                chk("wait_wen",  32'(bus.wb_wen),  0);
            end
            bus.mem_ready = 1'b1;
            bus.mem_rdata = rdata;
            #1 if (bus.stall) stalls++;
            chk("stall_cycles", 32'(stalls), 32'(waits + 1));
            step();
            bus.mem_ready = 1'b0;
            bus.ex_valid  = 1'b0;
            wen = !mw && rw && (rd != 0);
            if (wen) begin
                exp_wa = rd;
                exp_wd = ref_load(f3, a, rdata);
            end
            chk("done_req", 32'(bus.mem_req), 0);
            chk("done_wen", 32'(bus.wb_wen),  32'(wen));
            chk("done_wa",  32'(bus.wb_wa),   32'(exp_wa));
            chk("done_wd",  bus.wb_wd,        exp_wd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset             = 1'b0;
        bus.ex_valid      = 1'b0;
        bus.ex_rd         = '0;
        bus.ex_regwrite   = 1'b0;
        bus.ex_memread    = 1'b0;
        bus.ex_memwrite   = 1'b0;
        bus.ex_funct3     = '0;
        bus.ex_alu_result = '0;
        bus.ex_store_data = '0;
        bus.mem_ready     = 1'b0;
        bus.mem_rdata     = '0;
        exp_wa            = '0;
        exp_wd            = '0;
        #1 check_zero("rst");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        do_op(1'b1, 5'd5, 1'b0, 1'b0, F3_W, 32'h1234, 32'h0, 0, 32'h0);
        chk("tp_alu_wa", 32'(bus.wb_wa), 5);
        chk("tp_alu_wd", bus.wb_wd, 32'h1234);

        do_op(1'b1, 5'd3, 1'b1, 1'b0, F3_B, 32'h103, 32'h0, 3, 32'h80FF_FF00);
        chk("tp_lb_wd",   bus.wb_wd,    32'hFFFF_FF80);
        chk("tp_lb_addr", bus.mem_addr, 32'h100);
        do_op(1'b1, 5'd3, 1'b1, 1'b0, F3_BU, 32'h103, 32'h0, 3, 32'h80FF_FF00);
        chk("tp_lbu_wd", bus.wb_wd, 32'h80);

        do_op(1'b1, 5'd4, 1'b0, 1'b1, F3_H, 32'h202, 32'h0000_ABCD, 1, 32'h0);
        chk("tp_sh_be",    32'(bus.mem_be), 32'hC);
        chk("tp_sh_wdata", bus.mem_wdata,   32'hABCD_ABCD);
        chk("tp_sh_we",    32'(bus.mem_we), 1);

        do_op(1'b1, 5'd6, 1'b1, 1'b0, F3_W, 32'h6, 32'h0, 0, 32'h0);

        do_op(1'b1, 5'd0, 1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1, 32'h5555_5555);
        chk("tp_x0_wa_hold", 32'(bus.wb_wa), 3);

        for (int n = 0; n < 60; n++) begin
            int          kind;
            logic [2:0]  f3;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            f3   = 3'($urandom_range(0, 7));
            a    = $urandom();
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            do_op(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  kind == 1, kind == 2, f3, a, $urandom(),
                  $urandom_range(0, 3), $urandom());
        end

        // Reset while an access is outstanding.
        bus.ex_valid      = 1'b1;
        bus.ex_rd         = 5'd7;
        bus.ex_regwrite   = 1'b1;
        bus.ex_memread    = 1'b1;
        bus.ex_memwrite   = 1'b0;
        bus.ex_funct3     = F3_W;
        bus.ex_alu_result = 32'h40;
        bus.mem_ready     = 1'b0;
        step();
        bus.ex_valid = 1'b0;
        chk("rmw_req", 32'(bus.mem_req), 1);
        step();
        #2 reset = 1'b0;
        #1 check_zero("rmw");
        @(negedge clock);
        reset  = 1'b1;
        exp_wa = '0;
        exp_wd = '0;
        do_op(1'b1, 5'd9, 1'b0, 1'b0, F3_W, 32'hCAFE_F00D, 32'h0, 0, 32'h0);
        chk("rmw_alu_wd", bus.wb_wd, 32'hCAFE_F00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
